// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// Holds the controller state encoding, the winner codes and the score width.
package tow_pkg;

  localparam int SCORE_W = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_ROUND_END  = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times the post-round freeze.
// done is high during the last counted cycle, so the owner leaves on the following edge.
module hold_timer import tow_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_value,
  output logic              done
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - HOLD_W'(1);
    end
  end

  // Terminal-count compare: a load of N gives exactly N cycles before done clears.
  assign done = (count == HOLD_W'(1));

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer for a two-player tug-of-war game.
// State | meaning: IDLE wait start; PLAY round live; ROUND_END freeze; MATCH_OVER winner shown.
module match_controller import tow_pkg::*; #(
  parameter int WIN_TARGET  = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_win,
  input  logic               p2_win,
  output logic               play_enable,
  output logic               round_reset,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         match_winner
);

  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  state_t             state;
  logic               p1_only;
  logic               p2_only;
  logic               any_win;
  logic               p1_takes;
  logic               p2_takes;
  logic               hold_load;
  logic               hold_done;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  assign p1_only  = p1_win & ~p2_win;
  assign p2_only  = p2_win & ~p1_win;
  assign any_win  = p1_win | p2_win;
  assign p1_next  = p1_score + SCORE_W'(1);
  assign p2_next  = p2_score + SCORE_W'(1);
  assign p1_takes = p1_only && (p1_next == TARGET);
  assign p2_takes = p2_only && (p2_next == TARGET);

  // The timer loads on the same edge that enters ROUND_END.
  assign hold_load = (state == ST_PLAY) && any_win && !p1_takes && !p2_takes;

  hold_timer u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .done       (hold_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      play_enable  <= 1'b0;
      round_reset  <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_winner <= WIN_NONE;
    end else begin
      round_reset <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_PLAY;
            play_enable <= 1'b1;
            round_reset <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (p1_only) p1_score <= p1_next;
          if (p2_only) p2_score <= p2_next;
          if (p1_takes || p2_takes) begin
            state        <= ST_MATCH_OVER;
            play_enable  <= 1'b0;
            match_winner <= p1_takes ? WIN_P1 : WIN_P2;
          end else if (any_win) begin
            state       <= ST_ROUND_END;
            play_enable <= 1'b0;
          end
        end
        ST_ROUND_END: begin
          if (hold_done) begin
            state       <= ST_PLAY;
            play_enable <= 1'b1;
            round_reset <= 1'b1;
          end
        end
        ST_MATCH_OVER: begin
          if (start) begin
            state        <= ST_PLAY;
            play_enable  <= 1'b1;
            round_reset  <= 1'b1;
            p1_score     <= '0;
            p2_score     <= '0;
            match_winner <= WIN_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed walk through a full match, then randomized pulses against a cycle-level game model.
module tb_match_controller;
  import tow_pkg::*;

  localparam int T = 3;
  localparam int H = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       p1_win;
  logic       p2_win;
  logic       play_enable;
  logic       round_reset;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] match_winner;

  int compared;
  int mismatched;

  // Game model: phase 0 idle, 1 playing, 2 frozen, 3 match decided.
  int m_phase;
  int m_hold_left;
  int m_p1;
  int m_p2;
  int m_winner;
  int m_pe;
  int m_rr;

  match_controller #(.WIN_TARGET(T), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_win       (p1_win),
    .p2_win       (p2_win),
    .play_enable  (play_enable),
    .round_reset  (round_reset),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit w1, input bit w2, input bit r);
    if (r) begin
      m_phase = 0; m_hold_left = 0; m_p1 = 0; m_p2 = 0;
      m_winner = 0; m_pe = 0; m_rr = 0;
      return;
    end
    m_rr = 0;
    case (m_phase)
      0: if (s) begin m_phase = 1; m_pe = 1; m_rr = 1; end
      1: begin
        if (w1 || w2) begin
          m_pe = 0;
          if (w1 && !w2) m_p1++;
          if (w2 && !w1) m_p2++;
          if (w1 != w2 && (m_p1 == T || m_p2 == T)) begin
            m_phase  = 3;
            m_winner = (m_p1 == T) ? 1 : 2;
          end else begin
            m_phase     = 2;
            m_hold_left = H;
          end
        end
      end
      2: begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_phase = 1; m_pe = 1; m_rr = 1; end
      end
      default: if (s) begin
        m_phase = 1; m_p1 = 0; m_p2 = 0; m_winner = 0; m_pe = 1; m_rr = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".play_enable"}, 8'(play_enable), 8'(m_pe));
    chk({tag, ".round_reset"}, 8'(round_reset), 8'(m_rr));
    chk({tag, ".p1_score"}, 8'(p1_score), 8'(m_p1));
    chk({tag, ".p2_score"}, 8'(p2_score), 8'(m_p2));
    chk({tag, ".match_winner"}, 8'(match_winner), 8'(m_winner));
  endtask

  task automatic step(input string tag, input bit s, input bit w1, input bit w2, input bit r);
    start = s; p1_win = w1; p2_win = w2; reset = r;
    @(posedge clk);
    model_step(s, w1, w2, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    start = 0; p1_win = 0; p2_win = 0; reset = 1;

    step("reset", 0, 0, 0, 1);
    step("reset2", 0, 0, 0, 1);
    chk("reset_state", 8'(dut.state), 8'(ST_IDLE));
    step("idle_win_ignored", 0, 1, 0, 0);
    step("start_with_win", 1, 1, 0, 0);
    chk("start_pe", 8'(play_enable), 8'd1);
    chk("start_rr", 8'(round_reset), 8'd1);
    step("play_first", 0, 0, 0, 0);
    chk("rr_cleared", 8'(round_reset), 8'd0);

    step("p1_round", 0, 1, 0, 0);
    chk("p1_score_one", 8'(p1_score), 8'd1);
    for (int i = 1; i < H; i++) step("hold_p1", (i == 2), 1, 1, 0);
    chk("hold_pe_low", 8'(play_enable), 8'd0);
    step("resume_p1", 0, 0, 0, 0);
    chk("resume_rr", 8'(round_reset), 8'd1);
    chk("resume_pe", 8'(play_enable), 8'd1);

    step("tie", 0, 1, 1, 0);
    chk("tie_scores", 8'({p1_score, p2_score}), 8'({3'd1, 3'd0}));
    for (int i = 1; i < H; i++) step("hold_tie", 0, 0, 0, 0);
    step("resume_tie", 0, 0, 0, 0);

    for (int r = 0; r < T; r++) begin
      step("p2_round", 0, 0, 1, 0);
      if (r < T - 1) begin
        for (int i = 1; i < H; i++) step("hold_p2", 0, 0, 0, 0);
        step("resume_p2", 0, 0, 0, 0);
      end
    end
    chk("match_over_state", 8'(dut.state), 8'(ST_MATCH_OVER));
    chk("winner_p2", 8'(match_winner), 8'(WIN_P2));
    step("over_win_ignored", 0, 1, 0, 0);
    step("over_win_ignored2", 0, 0, 1, 0);
    chk("over_scores", 8'({p1_score, p2_score}), 8'({3'd1, 3'd3}));

    step("rematch", 1, 0, 0, 0);
    chk("rematch_rr", 8'(round_reset), 8'd1);
    chk("rematch_scores", 8'({p1_score, p2_score}), 8'd0);
    step("rematch_p1", 0, 1, 0, 0);
    step("hold_mid1", 0, 0, 0, 0);
    step("reset_mid_hold", 1, 1, 1, 1);
    chk("reset_mid_state", 8'(dut.state), 8'(ST_IDLE));
    step("idle_after_reset", 0, 0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      step("random",
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match; legal range 1..7.
REQ-002 Parameter HOLD_CYCLES, default 8: length of the post-round freeze in clock cycles; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  player start/rematch request, already debounced and one-cycle-pulsed.
REQ-006 p1_win  input  1  one-cycle pulse: player 1 pulled the marker off the end this round.
REQ-007 p2_win  input  1  one-cycle pulse: player 2 pulled the marker off the end this round.
REQ-008 play_enable  output  1  high only while a round is live; gates the playfield and key inputs.
REQ-009 round_reset  output  1  one-cycle pulse that re-centres the playfield for a new round.
REQ-010 p1_score  output  3  player 1 round wins, unsigned.
REQ-011 p2_score  output  3  player 2 round wins, unsigned.
REQ-012 match_winner  output  2  2'b00 none, 2'b01 player 1, 2'b10 player 2; 2'b11 never driven.

Function
REQ-013 States: IDLE, PLAY, ROUND_END, MATCH_OVER; every output is registered.
REQ-014 IDLE: play_enable=0; start=1 -> PLAY on the next edge, with round_reset=1 for exactly that first PLAY cycle.
REQ-015 PLAY: play_enable=1; p1_win=1 and p2_win=0 -> p1_score+1 on the next edge.
REQ-016 PLAY: p2_win=1 and p1_win=0 -> p2_score+1 on the next edge.
REQ-017 PLAY: p1_win=1 and p2_win=1 in the same cycle -> tie; no score change; go to ROUND_END.
REQ-018 PLAY: any win pulse -> ROUND_END on the next edge, unless the incremented score equals WIN_TARGET.
REQ-019 If the incremented score equals WIN_TARGET -> MATCH_OVER on the same edge, with match_winner set to the scoring player.
REQ-020 ROUND_END: play_enable=0; win inputs ignored; hold timer loads HOLD_CYCLES on entry.
REQ-021 ROUND_END lasts exactly HOLD_CYCLES cycles, then goes to PLAY with round_reset=1 for that first PLAY cycle.
REQ-022 MATCH_OVER: play_enable=0; scores and match_winner held; win inputs ignored.
REQ-023 MATCH_OVER + start=1 -> PLAY on the next edge: both scores cleared to 0, match_winner=00, round_reset=1 for one cycle.
REQ-024 start is ignored in PLAY and ROUND_END.
REQ-025 Win pulses in IDLE are ignored, including one arriving in the same cycle as start.
REQ-026 Scores never exceed WIN_TARGET; no wrap-around is reachable.
REQ-027 round_reset is never high in two consecutive cycles.

Reset
REQ-028 reset=1 at a clock edge -> IDLE regardless of current state, including mid-round and mid-hold.
REQ-029 Reset values: play_enable=0, round_reset=0, p1_score=0, p2_score=0, match_winner=00; hold timer cleared.
REQ-030 Reset takes priority over start and over win pulses in the same cycle.

Structure
REQ-031 Package tow_pkg holds the state enum type, the match_winner encodings (NONE/P1/P2) and the score width constant (3).
REQ-032 The hold countdown is a sub-module hold_timer (load, count-down, done pulse), sized to 8 bits.
REQ-033 match_controller instantiates hold_timer exactly once.

Verification (bench parameters: WIN_TARGET=3, HOLD_CYCLES=4)
REQ-034 reset, then start pulse -> next cycle play_enable=1 and round_reset=1; following cycle round_reset=0.
REQ-035 In PLAY, p1_win pulse -> p1_score=1 next cycle; play_enable=0 for 4 cycles; then round_reset=1 and play_enable=1.
REQ-036 p1_win and p2_win in the same cycle -> scores unchanged (1/0); hold of 4 cycles, then play resumes.
REQ-037 Three p2_win rounds -> p2_score=3, match_winner=10, state MATCH_OVER; further wins leave scores at 1/3.
REQ-038 Then start -> scores 0/0, match_winner=00, round_reset=1; reset asserted 2 cycles into the next hold -> all outputs at reset values and state IDLE.
